// File: rtl/bram_dump_reader.sv
// bram_dump_reader: streams a contiguous run of words out of a shared BRAM
// read port into a ready/valid consumer, through a 2-entry output FIFO.
// Reads are issued only when their data is guaranteed a FIFO slot, so the
// BRAM never needs to be stalled. Optional feature macro:
//   BRAM_DUMP_CHECKSUM_EN - adds a running modulo-2^WIDTH sum of accepted words.
module bram_dump_reader #(
  parameter int  WIDTH     = 32,
  parameter int  SIZE      = 256,
  parameter int  NUM_COL   = 4,
  parameter int  COL_WIDTH = 8,
  localparam int LOGSIZE   = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LOGSIZE+2:0]   base_addr,
  input  logic [LOGSIZE:0]     word_count,
  output logic [LOGSIZE+2:0]   shared_bram_addr,
  output logic [NUM_COL-1:0]   bram_wr_en,
  output logic [WIDTH-1:0]     bram_din,
  input  logic [WIDTH-1:0]     bram_dout,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BRAM_DUMP_CHECKSUM_EN
  output logic [WIDTH-1:0]     checksum,
`endif
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LOGSIZE-1:0]   word_idx_q, word_idx_d;
  logic [LOGSIZE:0]     issue_cnt_q, issue_cnt_d;
  logic [LOGSIZE:0]     accept_cnt_q, accept_cnt_d;
  logic [LOGSIZE+2:0]   addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [WIDTH-1:0]     fifo_q [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;

  logic                 pop;
  logic                 issue;
  logic [2:0]           occ_after_pop;
  logic [LOGSIZE+2:0]   issue_addr;

  // The block is read-only on the shared port; the column-sized zero keeps the
  // byte-lane layout visible to anyone widening the write side later.
  assign bram_wr_en = '0;
  assign bram_din   = {NUM_COL{{COL_WIDTH{1'b0}}}};

  // Word alignment drops the low address bits; the top bit only exists so the
  // port matches the BRAM's byte address width.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{base_addr[LOGSIZE+2], base_addr[1:0]};

  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign pop       = out_valid && out_ready;

  // A slot freed by this cycle's pop counts as free, which is what lets a new
  // read go out every cycle while the consumer keeps up.
  assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue         = (state_q == RUN) && (issue_cnt_q != '0) && (occ_after_pop < 3'd2);
  assign issue_addr    = {1'b0, word_idx_q, 2'b00};

  // The address goes straight to the BRAM in the issue cycle so its data lands
  // on the next edge; otherwise the port holds the last issued address.
  assign shared_bram_addr = issue ? issue_addr : addr_q;

  // Next-state logic for the controller, counters and FIFO pointers.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    addr_d       = addr_q;
    inflight_d   = issue;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_idx_d   = base_addr[LOGSIZE+1:2];
          issue_cnt_d  = word_count;
          accept_cnt_d = word_count;
          state_d      = (word_count == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (pop && accept_cnt_q == {{LOGSIZE{1'b0}}, 1'b1}) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d      = issue_addr;
      word_idx_d  = (word_idx_q == LOGSIZE'(SIZE - 1)) ? '0 : word_idx_q + 1'b1;
      issue_cnt_d = issue_cnt_q - 1'b1;
    end

    if (pop) begin
      rd_ptr_d     = ~rd_ptr_q;
      accept_cnt_d = accept_cnt_q - 1'b1;
    end
    if (inflight_q) wr_ptr_d = ~wr_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= '0;
      // NOTE: the FIFO storage is reset because out_data is a visible output
      // that must read zero after reset; this only works for a tiny register
      // file, never for a RAM macro.
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      if (inflight_q) fifo_q[wr_ptr_q] <= bram_dout;
    end
  end

`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q;

  assign checksum = csum_q;

  // Running sum of accepted words, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (reset)                       csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (pop)                    csum_q <= csum_q + out_data;
  end
`endif

endmodule

// File: tb/tb_bram_dump_reader.sv
// Randomized self-checking bench for bram_dump_reader. A behavioural BRAM
// array feeds the DUT; the expected stream is built from the base/count rules.
module tb_bram_dump_reader;
  localparam int WIDTH     = 32;
  localparam int SIZE      = 256;
  localparam int NUM_COL   = 4;
  localparam int COL_WIDTH = 8;
  localparam int LOGSIZE   = $clog2(SIZE);

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [LOGSIZE+2:0]  base_addr;
  logic [LOGSIZE:0]    word_count;
  logic [LOGSIZE+2:0]  shared_bram_addr;
  logic [NUM_COL-1:0]  bram_wr_en;
  logic [WIDTH-1:0]    bram_din;
  logic [WIDTH-1:0]    bram_dout;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0]    checksum;
`endif

  logic [WIDTH-1:0] mem [SIZE];
  int checks = 0;
  int errors = 0;

  bram_dump_reader #(
    .WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .shared_bram_addr (shared_bram_addr),
    .bram_wr_en       (bram_wr_en),
    .bram_din         (bram_din),
    .bram_dout        (bram_dout),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
`ifdef BRAM_DUMP_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM model: data for the address seen at an edge appears after it.
  always @(posedge clk) bram_dout <= mem[shared_bram_addr[LOGSIZE+1:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_dump(input int base_word, input int count, input int mode,
                          input bit repulse, input bit do_reset,
                          output logic [WIDTH-1:0] sum);
    logic [WIDTH-1:0]   exp_q[$];
    logic [WIDTH-1:0]   held;
    logic [LOGSIZE+2:0] addr_before;
    bit                 stalled;
    bit                 any_valid;
    int                 accepts, dones, done_n, first_valid, first_acc, last_acc, budget;

    sum = '0;
    for (int i = 0; i < count; i++) exp_q.push_back(mem[(base_word + i) % SIZE]);
    accepts = 0; dones = 0; done_n = -1; first_valid = -1; first_acc = -1; last_acc = -1;
    stalled = 1'b0; any_valid = 1'b0; held = '0;
    budget = 40 * count + 20;

    @(negedge clk);
    addr_before = shared_bram_addr;
    base_addr   = (LOGSIZE+3)'(base_word * 4) | (LOGSIZE+3)'($urandom_range(0, 3));
    word_count  = (LOGSIZE+1)'(count);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int n = 1; n <= budget; n++) begin
      // Mid-dump input changes must have no effect.
      base_addr  = (LOGSIZE+3)'($urandom);
      word_count = (LOGSIZE+1)'($urandom);
      if (repulse && n == 3) start = 1'b1;
      if (repulse && n == 4) start = 1'b0;

      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n - 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      check("wr_en_zero", bram_wr_en, '0);
      check("din_zero", bram_din, '0);
      if (stalled) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, held);
      end
      if (out_valid) begin
        any_valid = 1'b1;
        if (first_valid < 0) first_valid = n;
      end

      if (done_n >= 0 && n == done_n + 1) begin
        check("busy_after_done", busy, 1'b0);
        check("done_width", done, 1'b0);
        break;
      end
      if (done) begin
        dones++;
        done_n = n;
        check("busy_at_done", busy, 1'b1);
`ifdef BRAM_DUMP_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
      end

      if (do_reset && accepts == 1 && out_valid) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_addr", shared_bram_addr, '0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("post_rst_valid", out_valid, 1'b0);
          check("post_rst_done", done, 1'b0);
        end
        return;
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          check("data", out_data, exp_q.pop_front());
        end
        sum = sum + out_data;
        accepts++;
        if (first_acc < 0) first_acc = n;
        last_acc = n;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;

      if (n == budget) check("timeout", 1'b0, 1'b1);
      @(negedge clk);
    end

    check("accept_count", accepts, count);
    check("done_count", dones, 1);
    check("leftover", exp_q.size(), 0);
    if (count == 0) begin
      check("zero_done_cycle", done_n, 1);
      check("zero_no_valid", any_valid, 1'b0);
      check("zero_no_read", shared_bram_addr, addr_before);
    end else begin
      check("first_valid_cycle", first_valid, 3);
      check("done_after_last", done_n, last_acc + 1);
      if (mode == 0) check("back_to_back", last_acc - first_acc, count - 1);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] sum;
    for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i * 3);
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_addr", shared_bram_addr, '0);
    check("reset_data", out_data, '0);
    reset = 1'b0;

    run_dump(4, 4, 0, 1'b0, 1'b0, sum);
    check("sum_12_15_18_21", sum, 66);
    run_dump(SIZE - 2, 4, 0, 1'b0, 1'b0, sum);
    check("wrap_sum", sum, WIDTH'(((SIZE - 2) + (SIZE - 1) + 0 + 1) * 3));
    run_dump(10, 3, 1, 1'b0, 1'b0, sum);
    run_dump(0, 0, 0, 1'b0, 1'b0, sum);
    run_dump(20, 8, 0, 1'b0, 1'b1, sum);
    run_dump(30, 8, 0, 1'b0, 1'b0, sum);
    run_dump(40, 6, 0, 1'b1, 1'b0, sum);

    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    for (int t = 0; t < 8; t++) begin
      run_dump($urandom_range(0, SIZE - 1), $urandom_range(1, 12), 2, 1'b0, 1'b0, sum);
    end
    run_dump(SIZE - 5, 20, 1, 1'b0, 1'b0, sum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
